// File: rtl/freq_counter_bcd.sv
`default_nettype none
// ============================================================================
// Module   : freq_counter_bcd
// Brief    : Counts sig_in rising edges between gate_en pulses; packed BCD out.
//            Optional macro FREQ_HOLD_EN adds a hold input freezing the result.
// Revision : 1.0 - initial release
// ============================================================================
module freq_counter_bcd #(
    parameter int DIGITS      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gate_en,
    input  logic                  sig_in,
`ifdef FREQ_HOLD_EN
    input  logic                  hold,
`endif
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  result_valid,
    output logic                  overflow,
    output logic                  armed
);

    localparam logic [0:0]          c_WAIT_GATE = 1'b0;
    localparam logic [0:0]          c_MEASURE   = 1'b1;
    localparam logic [4*DIGITS-1:0] c_ACC_ONE   = {{(4*DIGITS-1){1'b0}}, 1'b1};

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_rise;
    logic [4*DIGITS-1:0]    r_acc;
    logic [4*DIGITS-1:0]    w_acc_nxt;
    logic [4*DIGITS-1:0]    w_acc_inc;
    logic [DIGITS:0]        w_carry;
    logic                   r_ovf_acc;
    logic                   w_ovf_acc_nxt;
    logic                   w_latch;
    logic                   w_publish;
    logic [4*DIGITS-1:0]    r_bcd_out;
    logic                   r_result_valid;
    logic                   r_overflow;
    logic                   r_armed;

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

`ifdef FREQ_HOLD_EN
    assign w_publish = ~hold;
`else
    assign w_publish = 1'b1;
`endif

    // Single-cycle ripple increment; w_carry[DIGITS] doubles as the all-9s flag.
    assign w_carry[0] = 1'b1;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [3:0] w_d;
        assign w_d                  = r_acc[4*gi +: 4];
        assign w_carry[gi+1]        = w_carry[gi] & (w_d == 4'd9);
        assign w_acc_inc[4*gi +: 4] = !w_carry[gi] ? w_d :
                                      (w_d == 4'd9) ? 4'd0 : w_d + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_WAIT_GATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_ovf_acc_nxt = r_ovf_acc;
        w_latch       = 1'b0;
        case (r_state)
            c_WAIT_GATE: begin
                w_acc_nxt     = '0;
                w_ovf_acc_nxt = 1'b0;
                if (gate_en) begin
                    w_state_nxt = c_MEASURE;
                end
            end
            c_MEASURE: begin
                if (gate_en) begin
                    // An edge landing on the gate belongs to the new window.
                    w_latch       = w_publish;
                    w_acc_nxt     = w_rise ? c_ACC_ONE : '0;
                    w_ovf_acc_nxt = 1'b0;
                end else if (w_rise) begin
                    if (w_carry[DIGITS]) begin
                        w_ovf_acc_nxt = 1'b1;
                    end else begin
                        w_acc_nxt = w_acc_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = c_WAIT_GATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync         <= '0;
            r_hist         <= 1'b0;
            r_acc          <= '0;
            r_ovf_acc      <= 1'b0;
            r_bcd_out      <= '0;
            r_overflow     <= 1'b0;
            r_result_valid <= 1'b0;
            r_armed        <= 1'b0;
        end else begin
            r_sync         <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_hist         <= r_sync[SYNC_STAGES-1];
            r_acc          <= w_acc_nxt;
            r_ovf_acc      <= w_ovf_acc_nxt;
            r_result_valid <= w_latch;
            if (w_state_nxt == c_MEASURE) begin
                r_armed <= 1'b1;
            end
            if (w_latch) begin
                r_bcd_out  <= r_acc;
                r_overflow <= r_ovf_acc;
            end
        end
    end

    assign bcd_out      = r_bcd_out;
    assign result_valid = r_result_valid;
    assign overflow     = r_overflow;
    assign armed        = r_armed;

endmodule
`default_nettype wire
